// File: rtl/mod_inverse.sv
// Modular inverse for RSA key setup: d = e^-1 mod phi, found with the
// extended Euclidean algorithm, one quotient step per clock. Only the
// Bezout coefficient of e (the "t" sequence) is tracked. err flags
// operands with no inverse: gcd(e, phi) != 1, phi < 2 or e == 0.
module mod_inverse #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] phi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] gcd,
    output logic             err
);

    // Two guard bits keep the signed coefficient exact: |t| never exceeds phi.
    localparam int TW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINAL
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       old_r;
    logic [WIDTH-1:0]       r;
    logic [WIDTH-1:0]       phi_q;
    logic signed [TW-1:0]   old_t;
    logic signed [TW-1:0]   t;
    logic                   reject;

    logic [WIDTH-1:0]       q;
    logic [WIDTH-1:0]       q_r;
    logic signed [TW-1:0]   q_t;
    logic signed [TW-1:0]   d_fix;

    // Euclid step arithmetic and the final fold of a negative coefficient into [0, phi-1].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
        q     = '0;
        q_r   = '0;
        q_t   = '0;
        d_fix = old_t;
        if (r != '0) begin
            q = old_r / r;
        end
        q_r = q * r;
        q_t = signed'({2'b00, q}) * t;
        if (old_t[TW-1]) begin
            d_fix = old_t + signed'({2'b00, phi_q});
        end
    end

    // Control FSM plus datapath registers; all outputs are registered.
    // NOTE: reset is asynchronous so an abandoned run is cleared at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            old_r  <= '0;
            r      <= '0;
            phi_q  <= '0;
            old_t  <= '0;
            t      <= '0;
            reject <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            gcd    <= '0;
            err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the pre-edge values, which the swap-style Euclid step depends on.
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (phi < WIDTH'(2) || e == '0) begin
                            reject <= 1'b1;
                            state  <= FINAL;
                        end else begin
                            reject <= 1'b0;
                            old_r  <= phi;
                            r      <= e;
                            old_t  <= '0;
                            t      <= TW'(1);
                            phi_q  <= phi;
                            state  <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (r == '0) begin
                        state <= FINAL;
                    end else begin
                        old_r <= r;
                        r     <= old_r - q_r;
                        old_t <= t;
                        t     <= old_t - q_t;
                    end
                end
                FINAL: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    if (reject) begin
                        gcd <= '0;
                        err <= 1'b1;
                        d   <= '0;
                    end else begin
                        gcd <= old_r;
                        if (old_r != WIDTH'(1)) begin
                            err <= 1'b1;
                            d   <= '0;
                        end else begin
                            err <= 1'b0;
                            d   <= d_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
